// File: rtl/csr_file_pkg.sv
// -----------------------------------------------------------------------------
// csr_file_pkg
// Shared machine-mode CSR definitions for the RV32I softcore: CSR addresses,
// mcause exception codes, mstatus bit positions, the misa constant, the
// Zicsr operation encoding and the read-modify-write / access helpers.
// Imported by the CSR file, the decoder and the trap logic.
// -----------------------------------------------------------------------------
package csr_file_pkg;

   // CSR addresses
   localparam logic [11:0] CSR_MSTATUS   = 12'h300;
   localparam logic [11:0] CSR_MISA      = 12'h301;
   localparam logic [11:0] CSR_MTVEC     = 12'h305;
   localparam logic [11:0] CSR_MSCRATCH  = 12'h340;
   localparam logic [11:0] CSR_MEPC      = 12'h341;
   localparam logic [11:0] CSR_MCAUSE    = 12'h342;
   localparam logic [11:0] CSR_MTVAL     = 12'h343;
   localparam logic [11:0] CSR_MCYCLE    = 12'hB00;
   localparam logic [11:0] CSR_MCYCLEH   = 12'hB80;
   localparam logic [11:0] CSR_MINSTRET  = 12'hB02;
   localparam logic [11:0] CSR_MINSTRETH = 12'hB82;
   localparam logic [11:0] CSR_CYCLE     = 12'hC00;
   localparam logic [11:0] CSR_CYCLEH    = 12'hC80;
   localparam logic [11:0] CSR_INSTRET   = 12'hC02;
   localparam logic [11:0] CSR_INSTRETH  = 12'hC82;
   localparam logic [11:0] CSR_MVENDORID = 12'hF11;
   localparam logic [11:0] CSR_MARCHID   = 12'hF12;
   localparam logic [11:0] CSR_MIMPID    = 12'hF13;
   localparam logic [11:0] CSR_MHARTID   = 12'hF14;

   // mcause exception codes
   localparam logic [3:0] MCAUSE_INST_MISALIGNED  = 4'd0;
   localparam logic [3:0] MCAUSE_ILLEGAL_INST     = 4'd2;
   localparam logic [3:0] MCAUSE_LOAD_MISALIGNED  = 4'd4;
   localparam logic [3:0] MCAUSE_STORE_MISALIGNED = 4'd6;

   // mstatus layout
   localparam int          MSTATUS_MIE_BIT  = 3;
   localparam int          MSTATUS_MPIE_BIT = 7;
   localparam logic [31:0] MSTATUS_MPP_M    = 32'h0000_1800;

   // RV32I, no extensions
   localparam logic [31:0] MISA_VALUE = 32'h4000_0100;

   // Zicsr operation class
   typedef enum logic [1:0] {
      CSR_OP_NONE  = 2'd0,
      CSR_OP_WRITE = 2'd1,
      CSR_OP_SET   = 2'd2,
      CSR_OP_CLEAR = 2'd3
   } csr_op_e;

   // Zicsr read-modify-write result
   function automatic logic [31:0] csr_rmw(input csr_op_e op, input logic [31:0] old,
                                           input logic [31:0] src);
      logic [31:0] res;
      case (op)
         CSR_OP_WRITE: res = src;
         CSR_OP_SET:   res = old | src;
         CSR_OP_CLEAR: res = old & ~src;
         default:      res = old;
      endcase
      return res;
   endfunction

   // Read-only space (addr[11:10]==11) plus the read-only misa
   function automatic logic csr_is_read_only(input logic [11:0] addr);
      return (addr[11:10] == 2'b11) || (addr == CSR_MISA);
   endfunction

endpackage

// File: rtl/csr_file_if.sv
// -----------------------------------------------------------------------------
// csr_file_if
// Decoder-to-CSR-file access bus for Zicsr instructions.
//  csr_read/write/set/clear/imm : operation controls from the decoder
//  csr_addr                     : CSR address (inst[31:20])
//  rs1_data / zimm              : register or immediate source
//  csr_rdata                    : old CSR value (combinational)
//  csr_illegal                  : illegal-CSR flag (combinational)
// master = decoder side, slave = CSR file side.
// -----------------------------------------------------------------------------
interface csr_file_if;
   logic        csr_read;
   logic        csr_write;
   logic        csr_set;
   logic        csr_clear;
   logic        csr_imm;
   logic [11:0] csr_addr;
   logic [31:0] rs1_data;
   logic [4:0]  zimm;
   logic [31:0] csr_rdata;
   logic        csr_illegal;

   modport master (
      output csr_read, csr_write, csr_set, csr_clear, csr_imm,
      output csr_addr, rs1_data, zimm,
      input  csr_rdata, csr_illegal
   );

   modport slave (
      input  csr_read, csr_write, csr_set, csr_clear, csr_imm,
      input  csr_addr, rs1_data, zimm,
      output csr_rdata, csr_illegal
   );
endinterface

// File: rtl/csr_file_counter64.sv
// -----------------------------------------------------------------------------
// csr_file_counter64
// 64-bit event counter with independently writable 32-bit halves, used for
// mcycle and minstret.
//  clk, resetb : clock, synchronous active-low reset
//  inc         : count this cycle
//  wr_lo/wr_hi : replace low/high half with wdata
//  wdata       : write data
//  count       : current 64-bit value
// A half write replaces only that half and suppresses the increment of the
// whole counter in that cycle, so no carry reaches the other half.
// -----------------------------------------------------------------------------
module csr_file_counter64 (
   input  logic        clk,
   input  logic        resetb,
   input  logic        inc,
   input  logic        wr_lo,
   input  logic        wr_hi,
   input  logic [31:0] wdata,
   output logic [63:0] count
);

   logic [63:0] count_r;

   // Counter state: reset, half write, or increment with natural 2^64 wrap
   always_ff @(posedge clk) begin
      if (!resetb) begin
         count_r <= 64'd0;
      end else if (wr_lo) begin
         count_r[31:0] <= wdata;
      end else if (wr_hi) begin
         count_r[63:32] <= wdata;
      end else if (inc) begin
         count_r <= count_r + 64'd1;
      end else begin
         count_r <= count_r;
      end
   end

   assign count = count_r;

endmodule

// File: rtl/csr_file.sv
// -----------------------------------------------------------------------------
// csr_file
// Machine-mode CSR register file and trap-state holder for the RV32I softcore.
//  clk, resetb     : clock, synchronous active-low reset
//  bus (slave)     : Zicsr access from the decoder; returns old value and
//                    illegal flag combinationally
//  retire          : one instruction retires this cycle (minstret)
//  trap_valid      : take a trap (trap_cause, trap_pc, trap_tval)
//  mret            : MRET executing this cycle
//  mtvec_o         : trap vector target
//  mepc_o          : MRET return target
//  mstatus_mie     : global machine interrupt enable
// Same-cycle priority: reset > trap > mret > CSR write.
// -----------------------------------------------------------------------------
module csr_file
   import csr_file_pkg::*;
#(
   parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
   parameter logic [31:0] HART_ID     = 32'd0
) (
   input  logic        clk,
   input  logic        resetb,
   csr_file_if.slave   bus,
   input  logic        retire,
   input  logic        trap_valid,
   input  logic [3:0]  trap_cause,
   input  logic [31:0] trap_pc,
   input  logic [31:0] trap_tval,
   input  logic        mret,
   output logic [31:0] mtvec_o,
   output logic [31:0] mepc_o,
   output logic        mstatus_mie
);

   localparam logic [31:0] MTVEC_RESET_ALIGNED = MTVEC_RESET & ~32'd3;

   logic        mie_r;
   logic        mpie_r;
   logic [31:0] mtvec_r;
   logic [31:0] mscratch_r;
   logic [31:0] mepc_r;
   logic [31:0] mcause_r;
   logic [31:0] mtval_r;

   logic [63:0] mcycle_s;
   logic [63:0] minstret_s;

   csr_op_e     op_s;
   logic [31:0] src_s;
   logic        wr_req_s;
   logic        impl_s;
   logic [31:0] old_s;
   logic        illegal_s;
   logic        wr_en_s;
   logic [31:0] new_s;

   // Operation class from the decoder strobes
   always_comb begin
      op_s = CSR_OP_NONE;
      if (bus.csr_write) begin
         op_s = CSR_OP_WRITE;
      end else if (bus.csr_set) begin
         op_s = CSR_OP_SET;
      end else if (bus.csr_clear) begin
         op_s = CSR_OP_CLEAR;
      end else begin
         op_s = CSR_OP_NONE;
      end
   end

   assign src_s = bus.csr_imm ? {27'd0, bus.zimm} : bus.rs1_data;

   // Set/clear with a zero source is a pure read and must not count as a write
   always_comb begin
      wr_req_s = 1'b0;
      case (op_s)
         CSR_OP_WRITE: wr_req_s = bus.csr_read;
         CSR_OP_SET,
         CSR_OP_CLEAR: wr_req_s = bus.csr_read & (src_s != 32'd0);
         default:      wr_req_s = 1'b0;
      endcase
   end

   // Read mux: old CSR value and whether the address is implemented
   always_comb begin
      impl_s = 1'b1;
      old_s  = 32'd0;
      case (bus.csr_addr)
         CSR_MSTATUS: begin
            old_s                   = MSTATUS_MPP_M;
            old_s[MSTATUS_MIE_BIT]  = mie_r;
            old_s[MSTATUS_MPIE_BIT] = mpie_r;
         end
         CSR_MISA:      old_s = MISA_VALUE;
         CSR_MTVEC:     old_s = mtvec_r;
         CSR_MSCRATCH:  old_s = mscratch_r;
         CSR_MEPC:      old_s = mepc_r;
         CSR_MCAUSE:    old_s = mcause_r;
         CSR_MTVAL:     old_s = mtval_r;
         CSR_MCYCLE,
         CSR_CYCLE:     old_s = mcycle_s[31:0];
         CSR_MCYCLEH,
         CSR_CYCLEH:    old_s = mcycle_s[63:32];
         CSR_MINSTRET,
         CSR_INSTRET:   old_s = minstret_s[31:0];
         CSR_MINSTRETH,
         CSR_INSTRETH:  old_s = minstret_s[63:32];
         CSR_MVENDORID,
         CSR_MARCHID,
         CSR_MIMPID:    old_s = 32'd0;
         CSR_MHARTID:   old_s = HART_ID;
         default: begin
            impl_s = 1'b0;
            old_s  = 32'd0;
         end
      endcase
   end

   assign illegal_s = bus.csr_read &
                      (~impl_s | (wr_req_s & csr_is_read_only(bus.csr_addr)));

   // A trap discards any same-cycle CSR write
   assign wr_en_s = wr_req_s & ~illegal_s & ~trap_valid;
   assign new_s   = csr_rmw(op_s, old_s, src_s);

   assign bus.csr_rdata   = old_s;
   assign bus.csr_illegal = illegal_s;

   csr_file_counter64 u_mcycle (
      .clk    (clk),
      .resetb (resetb),
      .inc    (1'b1),
      .wr_lo  (wr_en_s && (bus.csr_addr == CSR_MCYCLE)),
      .wr_hi  (wr_en_s && (bus.csr_addr == CSR_MCYCLEH)),
      .wdata  (new_s),
      .count  (mcycle_s)
   );

   csr_file_counter64 u_minstret (
      .clk    (clk),
      .resetb (resetb),
      .inc    (retire & ~trap_valid),
      .wr_lo  (wr_en_s && (bus.csr_addr == CSR_MINSTRET)),
      .wr_hi  (wr_en_s && (bus.csr_addr == CSR_MINSTRETH)),
      .wdata  (new_s),
      .count  (minstret_s)
   );

   // mstatus interrupt-enable stack: reset > trap > mret > CSR write
   always_ff @(posedge clk) begin
      if (!resetb) begin
         mie_r  <= 1'b0;
         mpie_r <= 1'b0;
      end else if (trap_valid) begin
         mpie_r <= mie_r;
         mie_r  <= 1'b0;
      end else if (mret) begin
         mie_r  <= mpie_r;
         mpie_r <= 1'b1;
      end else if (wr_en_s && (bus.csr_addr == CSR_MSTATUS)) begin
         mie_r  <= new_s[MSTATUS_MIE_BIT];
         mpie_r <= new_s[MSTATUS_MPIE_BIT];
      end else begin
         mie_r  <= mie_r;
         mpie_r <= mpie_r;
      end
   end

   // Trap-state registers: trap capture overrides CSR writes
   always_ff @(posedge clk) begin
      if (!resetb) begin
         mepc_r   <= 32'd0;
         mcause_r <= 32'd0;
         mtval_r  <= 32'd0;
      end else if (trap_valid) begin
         mepc_r   <= trap_pc & ~32'd3;
         mcause_r <= {28'd0, trap_cause};
         mtval_r  <= trap_tval;
      end else begin
         mepc_r   <= (wr_en_s && (bus.csr_addr == CSR_MEPC))   ? (new_s & ~32'd3) : mepc_r;
         mcause_r <= (wr_en_s && (bus.csr_addr == CSR_MCAUSE)) ? new_s : mcause_r;
         mtval_r  <= (wr_en_s && (bus.csr_addr == CSR_MTVAL))  ? new_s : mtval_r;
      end
   end

   // Plain read/write registers; mtvec is direct mode only
   always_ff @(posedge clk) begin
      if (!resetb) begin
         mtvec_r    <= MTVEC_RESET_ALIGNED;
         mscratch_r <= 32'd0;
      end else begin
         mtvec_r    <= (wr_en_s && (bus.csr_addr == CSR_MTVEC))    ? (new_s & ~32'd3) : mtvec_r;
         mscratch_r <= (wr_en_s && (bus.csr_addr == CSR_MSCRATCH)) ? new_s : mscratch_r;
      end
   end

   assign mtvec_o     = mtvec_r;
   assign mepc_o      = mepc_r;
   assign mstatus_mie = mie_r;

endmodule

// File: tb/tb_csr_file.sv
// -----------------------------------------------------------------------------
// tb_csr_file
// Scoreboard bench for csr_file: stimulus pushes the expected response from a
// behavioural model; a monitor on the falling edge pops and compares.
// -----------------------------------------------------------------------------
module tb_csr_file;
   import csr_file_pkg::*;

   localparam logic [31:0] MTVEC_RST = 32'h0000_0100;
   localparam logic [31:0] HART      = 32'h0000_0005;

   typedef struct packed {
      bit          rb;
      bit          rd;
      bit          wr;
      bit          st;
      bit          cl;
      bit          im;
      logic [11:0] addr;
      logic [31:0] rs1;
      logic [4:0]  z;
      bit          ret;
      bit          trap;
      logic [3:0]  cause;
      logic [31:0] tpc;
      logic [31:0] tval;
      bit          mr;
   } stim_t;

   typedef struct packed {
      bit          chk;
      bit          illegal;
      logic [31:0] rdata;
      logic [31:0] mtvec;
      logic [31:0] mepc;
      bit          mie;
   } exp_t;

   logic        clk;
   logic        resetb;
   logic        retire;
   logic        trap_valid;
   logic [3:0]  trap_cause;
   logic [31:0] trap_pc;
   logic [31:0] trap_tval;
   logic        mret;
   logic [31:0] mtvec_o;
   logic [31:0] mepc_o;
   logic        mstatus_mie;

   csr_file_if bus ();

   csr_file #(.MTVEC_RESET(MTVEC_RST), .HART_ID(HART)) dut (
      .clk         (clk),
      .resetb      (resetb),
      .bus         (bus),
      .retire      (retire),
      .trap_valid  (trap_valid),
      .trap_cause  (trap_cause),
      .trap_pc     (trap_pc),
      .trap_tval   (trap_tval),
      .mret        (mret),
      .mtvec_o     (mtvec_o),
      .mepc_o      (mepc_o),
      .mstatus_mie (mstatus_mie)
   );

   int total = 0;
   int bad   = 0;
   exp_t sb[$];

   // reference model state
   bit          m_mie, m_mpie;
   logic [31:0] m_mtvec, m_mscratch, m_mepc, m_mcause, m_mtval;
   logic [63:0] m_mcycle, m_minstret;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      total++;
      if (act !== expv) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, expv);
      end
   endtask

   // monitor: compare what the DUT presents against the oldest expectation
   always @(negedge clk) begin
      exp_t e;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         if (e.chk) begin
            check("illegal", {31'd0, bus.csr_illegal}, {31'd0, e.illegal});
            if (!e.illegal) check("rdata", bus.csr_rdata, e.rdata);
         end
         check("mtvec_o", mtvec_o, e.mtvec);
         check("mepc_o", mepc_o, e.mepc);
         check("mstatus_mie", {31'd0, mstatus_mie}, {31'd0, e.mie});
      end
   end

   function automatic void model_reset();
      m_mie = 1'b0; m_mpie = 1'b0;
      m_mtvec = MTVEC_RST; m_mscratch = 32'd0; m_mepc = 32'd0;
      m_mcause = 32'd0; m_mtval = 32'd0;
      m_mcycle = 64'd0; m_minstret = 64'd0;
   endfunction

   // returns {implemented, value}
   function automatic logic [32:0] model_read(input logic [11:0] a);
      case (a)
         12'h300: return {1'b1, 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0)};
         12'h301: return {1'b1, 32'h4000_0100};
         12'h305: return {1'b1, m_mtvec};
         12'h340: return {1'b1, m_mscratch};
         12'h341: return {1'b1, m_mepc};
         12'h342: return {1'b1, m_mcause};
         12'h343: return {1'b1, m_mtval};
         12'hB00, 12'hC00: return {1'b1, m_mcycle[31:0]};
         12'hB80, 12'hC80: return {1'b1, m_mcycle[63:32]};
         12'hB02, 12'hC02: return {1'b1, m_minstret[31:0]};
         12'hB82, 12'hC82: return {1'b1, m_minstret[63:32]};
         12'hF11, 12'hF12, 12'hF13: return {1'b1, 32'd0};
         12'hF14: return {1'b1, HART};
         default: return {1'b0, 32'd0};
      endcase
   endfunction

   function automatic logic [31:0] src_of(input stim_t s);
      return s.im ? {27'd0, s.z} : s.rs1;
   endfunction

   function automatic bit model_wreq(input stim_t s);
      return s.rd && (s.wr || ((s.st || s.cl) && src_of(s) != 32'd0));
   endfunction

   function automatic bit model_illegal(input stim_t s);
      logic [32:0] rv;
      bit ro;
      rv = model_read(s.addr);
      ro = (s.addr >= 12'hC00) || (s.addr == 12'h301);
      return s.rd && (!rv[32] || (model_wreq(s) && ro));
   endfunction

   function automatic void model_update(input stim_t s);
      logic [31:0] oldv, src, newv;
      logic [63:0] ncyc, nins;
      oldv = model_read(s.addr) & 33'h0_FFFF_FFFF;
      src  = src_of(s);
      newv = s.wr ? src : (s.st ? (oldv | src) : (oldv & ~src));
      if (!s.rb) begin
         model_reset();
         return;
      end
      ncyc = m_mcycle + 64'd1;
      nins = m_minstret + ((s.ret && !s.trap) ? 64'd1 : 64'd0);
      if (model_wreq(s) && !model_illegal(s) && !s.trap) begin
         case (s.addr)
            12'hB00: ncyc = {m_mcycle[63:32], newv};
            12'hB80: ncyc = {newv, m_mcycle[31:0]};
            12'hB02: nins = {m_minstret[63:32], newv};
            12'hB82: nins = {newv, m_minstret[31:0]};
            12'h300: if (!s.mr) begin m_mie = newv[3]; m_mpie = newv[7]; end
            12'h305: m_mtvec = newv & ~32'd3;
            12'h340: m_mscratch = newv;
            12'h341: m_mepc = newv & ~32'd3;
            12'h342: m_mcause = newv;
            12'h343: m_mtval = newv;
            default: ;
         endcase
      end
      m_mcycle = ncyc;
      m_minstret = nins;
      if (s.trap) begin
         m_mepc = s.tpc & ~32'd3;
         m_mcause = {28'd0, s.cause};
         m_mtval = s.tval;
         m_mpie = m_mie;
         m_mie = 1'b0;
      end else if (s.mr) begin
         m_mie = m_mpie;
         m_mpie = 1'b1;
      end
   endfunction

   function automatic stim_t idle();
      stim_t s;
      s = '0;
      s.rb = 1'b1;
      return s;
   endfunction

   // op: 0 write, 1 set, 2 clear
   function automatic stim_t csr_op(input int op, input bit imm, input logic [11:0] a,
                                    input logic [31:0] v);
      stim_t s;
      s = idle();
      s.rd = 1'b1; s.wr = (op == 0); s.st = (op == 1); s.cl = (op == 2);
      s.im = imm; s.addr = a;
      if (imm) s.z = v[4:0]; else s.rs1 = v;
      return s;
   endfunction

   function automatic stim_t rd_csr(input logic [11:0] a);
      return csr_op(1, 1'b0, a, 32'd0);
   endfunction

   task automatic drive(input stim_t s);
      resetb = s.rb;
      bus.csr_read = s.rd; bus.csr_write = s.wr; bus.csr_set = s.st;
      bus.csr_clear = s.cl; bus.csr_imm = s.im; bus.csr_addr = s.addr;
      bus.rs1_data = s.rs1; bus.zimm = s.z;
      retire = s.ret; trap_valid = s.trap; trap_cause = s.cause;
      trap_pc = s.tpc; trap_tval = s.tval; mret = s.mr;
   endtask

   task automatic step(input stim_t s);
      exp_t e;
      logic [32:0] rv;
      @(posedge clk);
      #1;
      drive(s);
      rv = model_read(s.addr);
      e.chk = s.rd;
      e.illegal = model_illegal(s);
      e.rdata = rv[31:0];
      e.mtvec = m_mtvec;
      e.mepc = m_mepc;
      e.mie = m_mie;
      sb.push_back(e);
      model_update(s);
   endtask

   initial begin
      stim_t s;
      logic [11:0] addrs [0:22];
      addrs = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
                12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80, 12'hC02,
                12'hC82, 12'hF11, 12'hF12, 12'hF13, 12'hF14, 12'h7C0, 12'h123,
                12'hB00, 12'h340};

      s = idle();
      s.rb = 1'b0;
      drive(s);
      @(posedge clk);
      model_reset();

      // reset values
      step(rd_csr(CSR_MTVEC));
      step(rd_csr(CSR_MSTATUS));
      step(rd_csr(CSR_MHARTID));

      // mscratch read-modify-write
      step(csr_op(0, 1'b0, CSR_MSCRATCH, 32'hDEAD_BEEF));
      step(csr_op(1, 1'b0, CSR_MSCRATCH, 32'd0));
      step(csr_op(2, 1'b1, CSR_MSCRATCH, 32'h0000_000F));
      step(rd_csr(CSR_MSCRATCH));
      step(csr_op(0, 1'b0, CSR_MTVEC, 32'h0000_1237));
      step(rd_csr(CSR_MTVEC));

      // counter carry across halves
      step(csr_op(0, 1'b0, CSR_MCYCLE, 32'hFFFF_FFFF));
      step(csr_op(0, 1'b0, CSR_MCYCLEH, 32'd0));
      step(idle());
      step(rd_csr(CSR_MCYCLEH));
      step(rd_csr(CSR_MCYCLE));
      step(rd_csr(CSR_CYCLEH));

      // illegal accesses leave state unchanged
      step(csr_op(0, 1'b0, CSR_CYCLE, 32'h1234_5678));
      step(csr_op(0, 1'b0, CSR_MISA, 32'd0));
      step(csr_op(1, 1'b0, 12'h7C0, 32'd0));
      step(csr_op(1, 1'b0, CSR_MISA, 32'd0));
      step(rd_csr(CSR_CYCLE));

      // trap with same-cycle write and retire, then mret
      step(csr_op(1, 1'b1, CSR_MSTATUS, 32'h8));
      s = csr_op(0, 1'b0, CSR_MSCRATCH, 32'h1234_5678);
      s.ret = 1'b1; s.trap = 1'b1; s.cause = MCAUSE_ILLEGAL_INST;
      s.tpc = 32'h0000_0203; s.tval = 32'hCAFE_0001;
      step(s);
      step(rd_csr(CSR_MEPC));
      step(rd_csr(CSR_MCAUSE));
      step(rd_csr(CSR_MTVAL));
      step(rd_csr(CSR_MSTATUS));
      step(rd_csr(CSR_MSCRATCH));
      step(rd_csr(CSR_MINSTRET));
      s = idle(); s.mr = 1'b1;
      step(s);
      step(rd_csr(CSR_MSTATUS));

      // reset in the middle of a trap
      s = idle(); s.ret = 1'b1;
      step(s);
      s = csr_op(0, 1'b0, CSR_MSCRATCH, 32'h5555_AAAA);
      s.rb = 1'b0; s.trap = 1'b1; s.cause = MCAUSE_LOAD_MISALIGNED; s.tpc = 32'h44;
      step(s);
      step(rd_csr(CSR_MEPC));
      step(rd_csr(CSR_MSCRATCH));
      step(rd_csr(CSR_MINSTRET));
      step(rd_csr(CSR_MCYCLE));

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         s = idle();
         s.rd = ($urandom_range(0, 3) != 0);
         if (s.rd) begin
            case ($urandom_range(0, 2))
               0: s.wr = 1'b1;
               1: s.st = 1'b1;
               default: s.cl = 1'b1;
            endcase
            s.im = $urandom_range(0, 1);
            s.addr = addrs[$urandom_range(0, 22)];
            s.rs1 = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
            s.z = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom);
         end else begin
            s.mr = ($urandom_range(0, 7) == 0);
         end
         s.ret = $urandom_range(0, 1);
         s.trap = ($urandom_range(0, 15) == 0);
         s.cause = 4'($urandom_range(0, 3) * 2);
         s.tpc = $urandom;
         s.tval = $urandom;
         s.rb = ($urandom_range(0, 199) != 0);
         step(s);
      end

      step(idle());
      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
